// File: rtl/ext_pkg.sv
// ext_pkg: shared op encodings, op type and buffer entry layout for the
// pipelined immediate/load extender.
package ext_pkg;

  localparam int unsigned EXT_DATA_W = 32;
  localparam int unsigned EXT_TAG_W  = 5;

  typedef logic [2:0] ext_op_t;

  localparam ext_op_t EXT_SIGN     = 3'd0;
  localparam ext_op_t EXT_ZERO     = 3'd1;
  localparam ext_op_t EXT_LUI      = 3'd2;
  localparam ext_op_t EXT_SIGN_SHL = 3'd3;
  localparam ext_op_t EXT_LB       = 3'd4;
  localparam ext_op_t EXT_LBU      = 3'd5;
  localparam ext_op_t EXT_LH       = 3'd6;
  localparam ext_op_t EXT_LHU      = 3'd7;

  // Buffer entry at the default widths; ext_pipe declares the same layout
  // sized by its own parameters.
  typedef struct packed {
    logic                  valid;
    logic [EXT_DATA_W-1:0] data;
    logic [EXT_TAG_W-1:0]  tag;
    logic                  err;
  } ext_entry_t;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational op -> result/err compute.
// Load ops (LB/LBU/LH/LHU) exist only when EXT_LOAD_MODES_EN is defined;
// otherwise they return data=0, err=1.
module ext_core
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned SHIFT  = 2,
  parameter int unsigned OFF_W  = $clog2(DATA_W/8)
) (
  input  ext_op_t           op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [DATA_W-1:0] sx;
  logic [DATA_W-1:0] zx;
  logic [DATA_W-1:0] lui;

`ifdef EXT_LOAD_MODES_EN
  logic [OFF_W+2:0]  bpos;
  logic [OFF_W+2:0]  hpos;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [DATA_W-1:0] bsx;
  logic [DATA_W-1:0] bzx;
  logic [DATA_W-1:0] hsx;
  logic [DATA_W-1:0] hzx;

  // Byte/half select: half position is the byte position with off[0] dropped.
  always_comb begin
    bpos      = {off, 3'b000};
    hpos      = bpos;
    hpos[3:0] = '0;
    lb        = word[bpos +: 8];
    lh        = word[hpos +: 16];
    bsx       = lb[7] ? '1 : '0;
    bsx[7:0]  = lb;
    bzx       = '0;
    bzx[7:0]  = lb;
    hsx       = lh[15] ? '1 : '0;
    hsx[15:0] = lh;
    hzx       = '0;
    hzx[15:0] = lh;
  end
`else
  logic unused_load;
  assign unused_load = ^{word, off};
`endif

  // Immediate forms built at full DATA_W width, then the op mux.
  always_comb begin
    sx                        = imm[IMM_W-1] ? '1 : '0;
    sx[IMM_W-1:0]             = imm;
    zx                        = '0;
    zx[IMM_W-1:0]             = imm;
    lui                       = '0;
    lui[DATA_W-1 -: IMM_W]    = imm;
    data                      = '0;
    err                       = 1'b0;
    case (op)
      EXT_SIGN:     data = sx;
      EXT_ZERO:     data = zx;
      EXT_LUI:      data = lui;
      EXT_SIGN_SHL: data = sx << SHIFT;
`ifdef EXT_LOAD_MODES_EN
      EXT_LB:       data = bsx;
      EXT_LBU:      data = bzx;
      EXT_LH:       data = hsx;
      EXT_LHU:      data = hzx;
`endif
      default:      err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate/load extender with valid/ready handshake and
// a 2-entry skid buffer (main M drives outputs, skid S absorbs a stall).
// Optional load modes: define EXT_LOAD_MODES_EN.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned SHIFT  = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_op,
  input  logic [IMM_W-1:0]             in_imm,
  input  logic [DATA_W-1:0]            in_word,
  input  logic [$clog2(DATA_W/8)-1:0]  in_off,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_err
);

  localparam int unsigned OFF_W = $clog2(DATA_W/8);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } entry_t;

  entry_t            m;
  entry_t            s;
  entry_t            in_e;
  logic [DATA_W-1:0] core_data;
  logic              core_err;
  logic              accept;
  logic              m_free;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .SHIFT  (SHIFT),
    .OFF_W  (OFF_W)
  ) u_core (
    .op   (ext_op_t'(in_op)),
    .imm  (in_imm),
    .word (in_word),
    .off  (in_off),
    .data (core_data),
    .err  (core_err)
  );

  // Handshake decode; in_ready depends only on registered S.valid and reset.
  always_comb begin
    in_ready   = !s.valid && !reset;
    accept     = in_valid && in_ready;
    m_free     = !m.valid || out_ready;
    in_e.valid = 1'b1;
    in_e.data  = core_data;
    in_e.tag   = in_tag;
    in_e.err   = core_err;
  end

  // M/S buffer: S refills M first; a new beat goes to M when it frees up,
  // else to S. Flush drops only valid bits; reset also zeroes the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      m <= '0;
      s <= '0;
    end else if (flush) begin
      m.valid <= 1'b0;
      s.valid <= 1'b0;
    end else if (m_free) begin
      if (s.valid) begin
        m       <= s;
        s.valid <= 1'b0;
      end else if (accept) begin
        m <= in_e;
      end else begin
        m.valid <= 1'b0;
      end
    end else if (accept) begin
      s <= in_e;
    end
  end

  // Outputs come straight from M so they hold while stalled.
  always_comb begin
    out_valid = m.valid;
    out_data  = m.data;
    out_tag   = m.tag;
    out_err   = m.err;
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe (default parameters).
// Expectations follow EXT_LOAD_MODES_EN when it is defined for the build.
module tb_ext_pipe;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int TW = 5;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [IW-1:0] in_imm;
  logic [DW-1:0] in_word;
  logic [OW-1:0] in_off;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_err;

  always #5 clk = ~clk;

  ext_pipe #(.DATA_W(DW), .IMM_W(IW), .SHIFT(2), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_imm(in_imm), .in_word(in_word), .in_off(in_off), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          e;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   errors = 0;
  int   checks = 0;
  logic acc = 1'b0;
  logic rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic e);
    exp_t r;
    r.d = d;
    r.t = t;
    r.e = e;
    return r;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [IW-1:0] imm,
                                 input logic [DW-1:0] w, input logic [OW-1:0] off,
                                 input logic [TW-1:0] tag);
    exp_t          r;
    logic [DW-1:0] sh;
    logic [7:0]    b;
    logic [15:0]   h;
    r.t = tag;
    r.e = 1'b0;
    r.d = '0;
    sh  = w >> (8 * int'(off));
    b   = sh[7:0];
    sh  = w >> (16 * (int'(off) / 2));
    h   = sh[15:0];
    case (op)
      3'd0: r.d = DW'($signed(imm));
      3'd1: r.d = DW'(imm);
      3'd2: r.d = {imm, 16'h0000};
      3'd3: r.d = DW'($signed(imm)) << 2;
`ifdef EXT_LOAD_MODES_EN
      3'd4: r.d = DW'($signed(b));
      3'd5: r.d = DW'(b);
      3'd6: r.d = DW'($signed(h));
      default: r.d = DW'(h);
`else
      default: r.e = 1'b1;
`endif
    endcase
    return r;
  endfunction

  // One clock: observe transfers/accepts mid-cycle, then advance to negedge.
  task automatic step();
    exp_t e;
    #1;
    acc = in_valid && in_ready && !flush && !reset;
    if (out_valid && out_ready && !reset) begin
      if (q.size() == 0) begin
        chk("extra_beat", 64'(out_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("data", 64'(out_data), 64'(e.d));
        chk("tag",  64'(out_tag),  64'(e.t));
        chk("err",  64'(out_err),  64'(e.e));
      end
    end
    if (flush || reset) q.delete();
    if (acc) q.push_back(cur_exp);
    @(negedge clk);
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic [2:0] op, input logic [IW-1:0] imm, input logic [DW-1:0] w,
                       input logic [OW-1:0] off, input logic [TW-1:0] tag, input exp_t e);
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    in_word  = w;
    in_off   = off;
    in_tag   = tag;
    cur_exp  = e;
  endtask

  task automatic send(input logic [2:0] op, input logic [IW-1:0] imm, input logic [DW-1:0] w,
                      input logic [OW-1:0] off, input logic [TW-1:0] tag, input exp_t e,
                      output int tries);
    drive(op, imm, w, off, tag, e);
    tries = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      tries++;
      if (acc) break;
    end
    chk("accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_imm = '0;
    in_word = '0; in_off = '0; in_tag = '0; out_ready = 1'b0;
    cur_exp = '0;

    // Reset
    @(negedge clk);
    #1 chk("rst_in_ready", 64'(in_ready), 64'(0));
    step();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_out_tag",   64'(out_tag),   64'(0));
    chk("rst_out_err",   64'(out_err),   64'(0));
    #1 chk("post_rst_ready", 64'(in_ready), 64'(1));

    // Back-to-back immediates, one per cycle
    out_ready = 1'b1;
    send(3'd0, 16'h8001, '0, '0, 5'd1, mk(32'hFFFF8001, 5'd1, 1'b0), n);
    chk("lat_sign", 64'(out_valid), 64'(1));
    send(3'd1, 16'h8001, '0, '0, 5'd2, mk(32'h00008001, 5'd2, 1'b0), n);
    chk("tput_zero", 64'(n), 64'(1));
    send(3'd2, 16'h1234, '0, '0, 5'd3, mk(32'h12340000, 5'd3, 1'b0), n);
    chk("tput_lui", 64'(n), 64'(1));
    send(3'd3, 16'hFFFF, '0, '0, 5'd4, mk(32'hFFFFFFFC, 5'd4, 1'b0), n);
    chk("tput_shl", 64'(n), 64'(1));
    send(3'd3, 16'h4000, '0, '0, 5'd5, mk(32'h00010000, 5'd5, 1'b0), n);
    chk("lat_shl", 64'(out_valid), 64'(1));
    step(); step();
    chk("stream_drain", 64'(q.size()), 64'(0));

    // Load modes
`ifdef EXT_LOAD_MODES_EN
    send(3'd4, '0, 32'h80FF7F01, 2'd2, 5'd6, mk(32'hFFFFFFFF, 5'd6, 1'b0), n);
    send(3'd5, '0, 32'h80FF7F01, 2'd3, 5'd7, mk(32'h00000080, 5'd7, 1'b0), n);
    send(3'd6, '0, 32'h80FF7F01, 2'd2, 5'd8, mk(32'hFFFF80FF, 5'd8, 1'b0), n);
    send(3'd7, '0, 32'h80FF7F01, 2'd0, 5'd9, mk(32'h00007F01, 5'd9, 1'b0), n);
`else
    send(3'd4, 16'h1234, 32'h80FF7F01, 2'd1, 5'h1A, mk(32'h0, 5'h1A, 1'b1), n);
    send(3'd7, 16'h00FF, 32'h80FF7F01, 2'd0, 5'h1B, mk(32'h0, 5'h1B, 1'b1), n);
`endif
    step(); step();

    // Back-pressure: tags 1,2 accepted, tag 3 held until drain
    out_ready = 1'b0;
    send(3'd0, 16'h0001, '0, '0, 5'd1, mk(32'h1, 5'd1, 1'b0), n);
    send(3'd1, 16'h0002, '0, '0, 5'd2, mk(32'h2, 5'd2, 1'b0), n);
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    drive(3'd2, 16'h0003, '0, '0, 5'd3, mk(32'h00030000, 5'd3, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      chk("bp_hold_tag",   64'(out_tag),   64'(1));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (acc) break;
    end
    chk("bp_accept3", 64'(acc), 64'(1));
    in_valid = 1'b0;
    step(); step(); step();
    chk("bp_drain", 64'(q.size()), 64'(0));

    // Flush with buffer full
    out_ready = 1'b0;
    send(3'd0, 16'h0006, '0, '0, 5'd6, mk(32'h6, 5'd6, 1'b0), n);
    send(3'd0, 16'h0007, '0, '0, 5'd7, mk(32'h7, 5'd7, 1'b0), n);
    drive(3'd0, 16'h0009, '0, '0, 5'd9, mk(32'h9, 5'd9, 1'b0));
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready",  64'(in_ready),  64'(1));
    out_ready = 1'b1;
    step(); step(); step();
    chk("flush_quiet", 64'(out_valid), 64'(0));

    // Flush drops a beat offered while in_ready is high
    out_ready = 1'b0;
    send(3'd0, 16'h000A, '0, '0, 5'd10, mk(32'hA, 5'd10, 1'b0), n);
    drive(3'd0, 16'h000B, '0, '0, 5'd11, mk(32'hB, 5'd11, 1'b0));
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    step(); step();

    // Output transfer in the flush cycle still counts
    send(3'd1, 16'h00CC, '0, '0, 5'd12, mk(32'hCC, 5'd12, 1'b0), n);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush3_out_valid", 64'(out_valid), 64'(0));

    // Reset mid-stream
    out_ready = 1'b0;
    send(3'd0, 16'hFFF0, '0, '0, 5'd13, mk(32'hFFFFFFF0, 5'd13, 1'b0), n);
    send(3'd0, 16'hFFF1, '0, '0, 5'd14, mk(32'hFFFFFFF1, 5'd14, 1'b0), n);
    drive(3'd0, 16'hFFF2, '0, '0, 5'd15, mk(32'hFFFFFFF2, 5'd15, 1'b0));
    reset = 1'b1;
    #1 chk("rstm_in_ready", 64'(in_ready), 64'(0));
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("rstm_out_valid", 64'(out_valid), 64'(0));
    chk("rstm_out_data",  64'(out_data),  64'(0));
    chk("rstm_out_tag",   64'(out_tag),   64'(0));
    #1 chk("rstm_in_ready_after", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    step(); step();

    // Random traffic with random back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [2:0]    op;
      logic [IW-1:0] imm;
      logic [DW-1:0] w;
      logic [OW-1:0] off;
      logic [TW-1:0] tg;
      op  = 3'($urandom_range(0, 7));
      imm = IW'($urandom);
      w   = DW'($urandom);
      off = OW'($urandom_range(0, 3));
      tg  = TW'($urandom);
      send(op, imm, w, off, tg, model(op, imm, w, off, tg), n);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rand_drain", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender.
- Extends immediates and, optionally, load data; carries a tag alongside the result.
- Uses a valid/ready handshake with a 2-entry skid buffer, sitting between decode/MEM and the next pipeline stage.
- Sustains one result per cycle under back-pressure, with 1-cycle latency.

Parameters:
- DATA_W, 32: result width; multiple of 16, at least IMM_W.
- IMM_W, 16: immediate width.
- SHIFT, 2: left-shift amount for SIGN_SHL; must be less than DATA_W.
- TAG_W, 5: width of the sideband tag passed through unchanged.

Ports:
- clk in 1: clock; all state updates on the rising edge.
- reset in 1: synchronous, active-high reset.
- flush in 1: synchronous discard of all buffered entries.
- in_valid in 1: input beat valid.
- in_ready out 1: block can accept a beat.
- in_op in 3: extension mode; encoding under Behaviour.
- in_imm in IMM_W: immediate operand.
- in_word in DATA_W: load word; used by load modes only.
- in_off in $clog2(DATA_W/8): byte offset within in_word.
- in_tag in TAG_W: sideband tag.
- out_valid out 1: output beat valid.
- out_ready in 1: consumer accepts the beat.
- out_data out DATA_W: extended result.
- out_tag out TAG_W: tag travelling with out_data.
- out_err out 1: op was illegal in this build; out_data is 0.

Behaviour:
- Reset: one clock, synchronous, active-high, as already decided.
  - Sync reset clears both entries.
  - out_valid=0, out_data=0, out_tag=0, out_err=0.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset.
- Op encoding:
  - 0 SIGN: sign-extend in_imm.
  - 1 ZERO: zero-extend in_imm.
  - 2 LUI: in_imm in bits [DATA_W-1:DATA_W-IMM_W], zeros below.
  - 3 SIGN_SHL: sign-extend in_imm, then shift left by SHIFT; bits shifted out are dropped.
  - 4 LB: sign-extend byte in_word[8*off+7:8*off].
  - 5 LBU: zero-extend that same byte.
  - 6 LH: sign-extend the half selected by off[msb:1], with off[0] ignored.
  - 7 LHU: zero-extend that same half.
  - For DATA_W>32, LH/LHU select half index off>>1.
- Handshake:
  - Accept when in_valid & in_ready.
  - Transfer when out_valid & out_ready.
  - out_data, out_tag and out_err are held stable while out_valid & !out_ready.
- Latency: an accepted beat appears on out_valid on the next cycle when the output register is empty or draining.
- Buffer: main register M drives the outputs; skid register S catches a beat that arrives while M stalls.
  - in_ready = !S.valid, a registered state bit, so there is no combinational path from out_ready.
  - Accept with M empty, or M draining this cycle: the beat goes to M.
  - Accept with M full and not draining: the beat goes to S.
  - M drains while S is full: S moves to M and S is cleared.
  - Full (S valid): in_ready=0, and input is ignored even if in_valid=1.
  - Throughput is 1 beat/cycle when out_ready stays high.
- Flush: clears M.valid and S.valid next edge.
  - A beat presented in the flush cycle is dropped.
  - A beat transferring at the output in the flush cycle still counts as transferred.
  - Reset dominates flush.
- Reset mid-stream: all in-flight beats are lost; no partial output.
- Sign/zero rules are computed at DATA_W precision; no truncation of in_imm.

Optional Feature:
- Macro: EXT_LOAD_MODES_EN.
- Defined: ops 4-7 behave as listed above; out_err is always 0.
- Undefined: in_word and in_off are unused, and there is no byte/half mux logic.
  - Ops 4-7 produce out_data=0 and out_err=1, still passing the handshake and tag normally.

Decomposition:
- Package ext_pkg holds:
  - op localparams EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_SIGN_SHL, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU;
  - a 3-bit op typedef;
  - an entry struct {valid, data, tag, err}.
- Sub-module ext_core: purely combinational op→result/err compute, parametrised identically.
- ext_pipe owns the M/S buffering, flush and reset.

Test Plan:
- SIGN imm=16'h8001, ZERO imm=16'h8001, LUI imm=16'h1234 with out_ready=1
  -> next cycles give 32'hFFFF8001, 32'h00008001, 32'h12340000 in order, one per cycle.
- SIGN_SHL imm=16'hFFFF -> 32'hFFFFFFFC; imm=16'h4000 -> 32'h00010000.
- With EXT_LOAD_MODES_EN, word=32'h80FF7F01:
  - LB off=2 -> 32'hFFFFFFFF; LBU off=3 -> 32'h00000080;
  - LH off=2 -> 32'hFFFF80FF; LHU off=0 -> 32'h00007F01.
- Without EXT_LOAD_MODES_EN: op=4 -> out_data=0, out_err=1, tag preserved.
- Back-pressure: out_ready=0 while 3 beats are offered with tags 1,2,3.
  - Tags 1 and 2 are accepted; in_ready falls after the 2nd; tag 3 is held.
  - After out_ready=1, outputs arrive in order 1,2,3 with no loss or duplication.
- Buffer full (2 beats), then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle beat never appears.
- Reset asserted mid-stream -> same as the flush case, plus out_data=0 and out_tag=0.
